// File: rtl/starfield_layers.sv
// Multi-layer parallax starfield over a 512x256 paint area, with its own display timing.
// Define STARFIELD_COLOUR_EN for tinted stars; the default build is greyscale.

module display #(
  parameter int CORDW = 16,
  parameter int MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame
);
  // Mode 0 is 640x480 60 Hz; mode 1 is a compact 516x3 raster with a 10-line vblank.
  localparam int H_RES  = (MODE == 1) ? 516 : 640;
  localparam int H_FP   = (MODE == 1) ? 2 : 16;
  localparam int H_SYNC = (MODE == 1) ? 4 : 96;
  localparam int H_BP   = (MODE == 1) ? 6 : 48;
  localparam int V_RES  = (MODE == 1) ? 3 : 480;
  localparam int V_FP   = (MODE == 1) ? 2 : 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = (MODE == 1) ? 6 : 33;

  localparam logic signed [CORDW-1:0] H_STA  = CORDW'(-(H_FP + H_SYNC + H_BP));
  localparam logic signed [CORDW-1:0] HS_STA = CORDW'(-(H_SYNC + H_BP));
  localparam logic signed [CORDW-1:0] HS_END = CORDW'(-H_BP);
  localparam logic signed [CORDW-1:0] H_END  = CORDW'(H_RES - 1);
  localparam logic signed [CORDW-1:0] V_STA  = CORDW'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [CORDW-1:0] VS_STA = CORDW'(-(V_SYNC + V_BP));
  localparam logic signed [CORDW-1:0] VS_END = CORDW'(-V_BP);
  localparam logic signed [CORDW-1:0] V_END  = CORDW'(V_RES - 1);
  localparam logic signed [CORDW-1:0] ONE    = CORDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sx <= H_STA;
      sy <= V_STA;
    end else if (sx == H_END) begin
      sx <= H_STA;
      sy <= (sy == V_END) ? V_STA : sy + ONE;
    end else begin
      sx <= sx + ONE;
    end
  end

  // Syncs are active low; blanking precedes the active region in both axes.
  always_comb begin
    hsync = !(sx >= HS_STA && sx < HS_END);
    vsync = !(sy >= VS_STA && sy < VS_END);
    de    = !sx[CORDW-1] && !sy[CORDW-1];
    frame = (sx == H_STA) && (sy == V_STA);
  end
endmodule

// state   | meaning
// IDLE    | waiting for frame_start; fseed holds
// ADVANCE | stepping fseed once per cycle, cnt steps remaining
module starfield_layers #(
  parameter int          BPC          = 5,
  parameter int          CORDW        = 16,
  parameter int          DISPLAY_MODE = 0,
  parameter int          LAYERS       = 3,
  parameter int          DENSITY      = 6,
  parameter logic [31:0] SPEEDS       = 32'h00_04_02_01,
  parameter logic [67:0] SEEDS        = {17'h0081A, 17'h00567, 17'h002B4, 17'h00001}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scroll_en,
  output logic signed [CORDW-1:0] disp_x,
  output logic signed [CORDW-1:0] disp_y,
  output logic                    disp_hsync,
  output logic                    disp_vsync,
  output logic                    disp_de,
  output logic                    disp_frame,
  output logic [BPC-1:0]          disp_r,
  output logic [BPC-1:0]          disp_g,
  output logic [BPC-1:0]          disp_b
);
  localparam logic [16:0] TAPS = 17'b10010000000000000;
  localparam logic signed [CORDW-1:0] P_W = CORDW'(512);
  localparam logic signed [CORDW-1:0] P_H = CORDW'(256);

  typedef enum logic {IDLE, ADVANCE} layer_state_t;

  function automatic logic [16:0] lfsr_step(input logic [16:0] s);
    return {1'b0, s[16:1]} ^ (s[0] ? TAPS : 17'd0);
  endfunction

  logic signed [CORDW-1:0] dx, dy;
  logic hs, vs, de, frame_start, paint;

  display #(.CORDW(CORDW), .MODE(DISPLAY_MODE)) u_display (
    .clk(clk), .rst(rst), .sx(dx), .sy(dy),
    .hsync(hs), .vsync(vs), .de(de), .frame(frame_start)
  );

  assign paint = !dx[CORDW-1] && !dy[CORDW-1] && (dx < P_W) && (dy < P_H);

  logic [LAYERS-1:0] star;
  logic [BPC-1:0]    lr [LAYERS];
  logic [BPC-1:0]    lg [LAYERS];
  logic [BPC-1:0]    lb [LAYERS];

  for (genvar k = 0; k < LAYERS; k++) begin : g_layer
    localparam logic [7:0]  SPEED = SPEEDS[8*k +: 8];
    localparam logic [16:0] SEED  = SEEDS[17*k +: 17];

    layer_state_t state, state_nx;
    logic [7:0]   cnt, cnt_nx;
    logic [16:0]  fseed, fseed_nx, wreg, wreg_nx;

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      fseed_nx = fseed;
      case (state)
        IDLE: begin
          if (frame_start && scroll_en && (SPEED != 8'd0)) begin
            state_nx = ADVANCE;
            cnt_nx   = SPEED;
          end
        end
        ADVANCE: begin
          fseed_nx = lfsr_step(fseed);
          cnt_nx   = cnt - 8'd1;
          if (cnt == 8'd1) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase

      // Rewind to the frame seed throughout vblank, walk the sequence across paint pixels.
      wreg_nx = wreg;
      if (dy[CORDW-1]) wreg_nx = fseed;
      else if (paint)  wreg_nx = lfsr_step(wreg);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= 8'd0;
        fseed <= SEED;
        wreg  <= SEED;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        fseed <= fseed_nx;
        wreg  <= wreg_nx;
      end
    end

    assign star[k] = &wreg[16 -: DENSITY];

`ifdef STARFIELD_COLOUR_EN
    assign lr[k] = wreg[BPC-1:0] >> k;
    assign lg[k] = wreg[BPC+3:4] >> k;
    assign lb[k] = wreg[BPC+7:8] >> k;
`else
    assign lr[k] = wreg[BPC-1:0] >> k;
    assign lg[k] = wreg[BPC-1:0] >> k;
    assign lb[k] = wreg[BPC-1:0] >> k;
`endif
  end

  logic           hit;
  logic [BPC-1:0] sel_r, sel_g, sel_b, col_r, col_g, col_b;

  always_comb begin
    hit   = 1'b0;
    sel_r = '0;
    sel_g = '0;
    sel_b = '0;
    // Walk back to front so the frontmost (lowest index) star is written last.
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (star[k]) begin
        hit   = 1'b1;
        sel_r = lr[k];
        sel_g = lg[k];
        sel_b = lb[k];
      end
    end

    col_r = '0;
    col_g = '0;
    col_b = '0;
    if (de) begin
      if (paint && hit) begin
        col_r = sel_r;
        col_g = sel_g;
        col_b = sel_b;
      end else begin
        col_r = BPC'(2);
        col_g = '0;
        col_b = BPC'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_x     <= '0;
      disp_y     <= '0;
      disp_hsync <= 1'b0;
      disp_vsync <= 1'b0;
      disp_de    <= 1'b0;
      disp_frame <= 1'b0;
      disp_r     <= '0;
      disp_g     <= '0;
      disp_b     <= '0;
    end else begin
      disp_x     <= dx;
      disp_y     <= dy;
      disp_hsync <= hs;
      disp_vsync <= vs;
      disp_de    <= de;
      disp_frame <= frame_start;
      disp_r     <= col_r;
      disp_g     <= col_g;
      disp_b     <= col_b;
    end
  end
endmodule

// File: tb/tb_starfield_layers.sv
// Scoreboard bench for starfield_layers on the compact display mode: frames are
// predicted into a queue as they are launched and a negedge monitor checks each pixel.
module tb_starfield_layers;
  localparam int BPC    = 5;
  localparam int CORDW  = 16;
  localparam int LAYERS = 3;
  localparam int DENS   = 3;
  localparam logic [31:0] SPEEDS = 32'h00_04_02_01;
  localparam logic [16:0] TAPS   = 17'b10010000000000000;
  localparam int H_ACT = 516;
  localparam int V_ACT = 3;
  localparam int FRAME = 528 * 13;
  localparam int X0    = -12;
  localparam int Y0    = -10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scroll_en = 1'b0;
  logic signed [CORDW-1:0] disp_x, disp_y;
  logic disp_hsync, disp_vsync, disp_de, disp_frame;
  logic [BPC-1:0] disp_r, disp_g, disp_b;

  starfield_layers #(
    .BPC(BPC), .CORDW(CORDW), .DISPLAY_MODE(1), .LAYERS(LAYERS),
    .DENSITY(DENS), .SPEEDS(SPEEDS)
  ) dut (
    .clk(clk), .rst(rst), .scroll_en(scroll_en),
    .disp_x(disp_x), .disp_y(disp_y),
    .disp_hsync(disp_hsync), .disp_vsync(disp_vsync),
    .disp_de(disp_de), .disp_frame(disp_frame),
    .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int r;
    int g;
    int b;
  } pix_t;

  pix_t        exp_q[$];
  logic [16:0] fs [LAYERS];
  int checks = 0;
  int errors = 0;

  function automatic logic [16:0] step(input logic [16:0] s);
    return {1'b0, s[16:1]} ^ (s[0] ? TAPS : 17'd0);
  endfunction

  function automatic logic [16:0] seed_of(input int k);
    return 17'h1 + 17'(k) * 17'h2B3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < LAYERS; k++) fs[k] = seed_of(k);
  endtask

  task automatic push_frame();
    logic [16:0] w [LAYERS];
    logic [4:0]  v;
    pix_t        p;
    for (int k = 0; k < LAYERS; k++) w[k] = fs[k];
    for (int y = 0; y < V_ACT; y++) begin
      for (int x = 0; x < H_ACT; x++) begin
        p.x = x; p.y = y; p.r = 2; p.g = 0; p.b = 1;
        if (x < 512) begin
          for (int k = LAYERS - 1; k >= 0; k--) begin
            if (&w[k][16 -: DENS]) begin
              v = w[k][4:0] >> k;
              p.r = int'(v);
`ifdef STARFIELD_COLOUR_EN
              v = w[k][8:4] >> k;
              p.g = int'(v);
              v = w[k][12:8] >> k;
              p.b = int'(v);
`else
              p.g = p.r;
              p.b = p.r;
`endif
            end
          end
          for (int k = 0; k < LAYERS; k++) w[k] = step(w[k]);
        end
        exp_q.push_back(p);
      end
    end
  endtask

  // Called on the negedge just before the frame_start edge.
  task automatic run_frame(input bit en);
    scroll_en = en;
    if (en) begin
      for (int k = 0; k < LAYERS; k++)
        for (int n = 0; n < int'(SPEEDS[8*k +: 8]); n++) fs[k] = step(fs[k]);
    end
    push_frame();
    repeat (FRAME) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, int'(disp_x), 0);
    chk({tag, "_y"}, int'(disp_y), 0);
    chk({tag, "_ctl"}, int'({disp_hsync, disp_vsync, disp_de, disp_frame}), 0);
    chk({tag, "_rgb"}, int'({disp_r, disp_g, disp_b}), 0);
  endtask

  always @(negedge clk) begin
    pix_t e;
    if (disp_de) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel: unexpected de at x=%0d y=%0d, none expected", disp_x, disp_y);
      end else begin
        e = exp_q.pop_front();
        if (int'(disp_x) != e.x || int'(disp_y) != e.y || int'(disp_r) != e.r ||
            int'(disp_g) != e.g || int'(disp_b) != e.b) begin
          errors++;
          $display("FAIL pixel: got (%0d,%0d) rgb %0d/%0d/%0d expected (%0d,%0d) rgb %0d/%0d/%0d",
                   disp_x, disp_y, disp_r, disp_g, disp_b, e.x, e.y, e.r, e.g, e.b);
        end
      end
    end else begin
      chk("blank_rgb", int'({disp_r, disp_g, disp_b}), 0);
    end
    if (disp_frame) begin
      chk("frame_x", int'(disp_x), X0);
      chk("frame_y", int'(disp_y), Y0);
    end
  end

  initial begin
    model_reset();
    rst = 1'b1;
    scroll_en = 1'b0;
    repeat (4) @(negedge clk);
    chk_all_zero("reset");

    rst = 1'b0;
    run_frame(1'b1);
    run_frame(1'b1);
    run_frame(1'b0);
    run_frame(1'b0);
    run_frame(1'b0);
    run_frame(1'b1);

    // Reset on the second advance cycle of the speed-4 layer.
    scroll_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    chk("midrst_queue", exp_q.size(), 0);
    rst = 1'b0;
    model_reset();
    run_frame(1'b1);

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
